// File: rtl/float_mult_pipe.sv
// float_mult_pipe: 3-stage pipelined IEEE-754 style multiplier with RNE rounding and flush-to-zero.
// Define FPU_MULT_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module float_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int FRAC_W = 10,
  localparam int FLOAT_W = 1 + EXP_W + FRAC_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] float1,
  input  logic [FLOAT_W-1:0] float2,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef FPU_MULT_FLAGS_EN
  output logic [3:0]         flags,
`endif
  output logic [FLOAT_W-1:0] product
);

  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * MW;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(1);
  localparam logic [FLOAT_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic stall;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, out_valid_d, out_valid_q;
  logic sign_p1_d, sign_p1_q, sign_p2_d, sign_p2_q;
  logic spc_p1_d, spc_p1_q, spc_p2_d, spc_p2_q;
  logic [FLOAT_W-1:0] spc_val_p1_d, spc_val_p1_q, spc_val_p2_d, spc_val_p2_q;
  logic signed [XW-1:0] exp_p1_d, exp_p1_q, exp_p2_d, exp_p2_q;
  logic [MW-1:0] mant_a_p1_d, mant_a_p1_q, mant_b_p1_d, mant_b_p1_q;
  logic [PW-1:0] prod_p2_d, prod_p2_q;
  logic [FLOAT_W-1:0] product_d, product_q;

  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, zero_x_inf;
  logic top, guard, sticky;
  logic [PW-2:0] norm;
  logic [MW-1:0] rnd;
  logic signed [XW-1:0] exp_r;

`ifdef FPU_MULT_FLAGS_EN
  logic inv_p1_d, inv_p1_q, inv_p2_d, inv_p2_q;
  logic ovf, unf, inexact;
  logic [3:0] flags_d, flags_q;
  assign flags = flags_q;
`endif

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // S1: unpack, classify, sign and biased exponent sum
  always_comb begin
    a_exp  = float1[FLOAT_W-2 -: EXP_W];
    b_exp  = float2[FLOAT_W-2 -: EXP_W];
    a_frac = float1[FRAC_W-1:0];
    b_frac = float2[FRAC_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == '1) && (a_frac == '0);
    b_inf  = (b_exp == '1) && (b_frac == '0);
    a_nan  = (a_exp == '1) && (a_frac != '0);
    b_nan  = (b_exp == '1) && (b_frac != '0);
    zero_x_inf = (a_zero & b_inf) | (a_inf & b_zero);

    vld_p1_d    = in_valid & in_ready;
    sign_p1_d   = float1[FLOAT_W-1] ^ float2[FLOAT_W-1];
    spc_p1_d    = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    if (a_nan | b_nan | zero_x_inf)
      spc_val_p1_d = QNAN;
    else if (a_inf | b_inf)
      spc_val_p1_d = {sign_p1_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else
      spc_val_p1_d = {sign_p1_d, {(FLOAT_W-1){1'b0}}};
    exp_p1_d    = XW'(a_exp) + XW'(b_exp) - BIAS_X;
    mant_a_p1_d = {1'b1, a_frac};
    mant_b_p1_d = {1'b1, b_frac};
`ifdef FPU_MULT_FLAGS_EN
    inv_p1_d = (a_nan & ~a_frac[FRAC_W-1]) | (b_nan & ~b_frac[FRAC_W-1]) | zero_x_inf;
`endif
  end

  // S2: mantissa multiply
  always_comb begin
    vld_p2_d     = vld_p1_q;
    sign_p2_d    = sign_p1_q;
    spc_p2_d     = spc_p1_q;
    spc_val_p2_d = spc_val_p1_q;
    exp_p2_d     = exp_p1_q;
    prod_p2_d    = PW'(mant_a_p1_q) * PW'(mant_b_p1_q);
`ifdef FPU_MULT_FLAGS_EN
    inv_p2_d = inv_p1_q;
`endif
  end

  // S3: normalise so the leading one sits at the top, then round-to-nearest-even and pack
  always_comb begin
    top    = prod_p2_q[PW-1];
    norm   = top ? prod_p2_q[PW-2:0] : {prod_p2_q[PW-3:0], 1'b0};
    guard  = norm[FRAC_W];
    sticky = |norm[FRAC_W-1:0];
    rnd    = {1'b0, norm[PW-2 -: FRAC_W]} + MW'(rne_up(norm[FRAC_W+1], guard, sticky));
    exp_r  = exp_p2_q + XW'(top) + XW'(rnd[FRAC_W]);

    out_valid_d = vld_p2_q;
    product_d   = {sign_p2_q, exp_r[EXP_W-1:0], rnd[FRAC_W-1:0]};
    if (spc_p2_q)
      product_d = spc_val_p2_q;
    else if (exp_r >= EXP_MAX)
      product_d = {sign_p2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (exp_r < EXP_MIN)
      product_d = {sign_p2_q, {(FLOAT_W-1){1'b0}}};
`ifdef FPU_MULT_FLAGS_EN
    ovf     = ~spc_p2_q & (exp_r >= EXP_MAX);
    unf     = ~spc_p2_q & (exp_r < EXP_MIN);
    inexact = ~spc_p2_q & (guard | sticky | ovf | unf);
    flags_d = {inv_p2_q & spc_p2_q, ovf, unf, inexact};
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
`ifdef FPU_MULT_FLAGS_EN
      flags_q     <= '0;
`endif
    end else if (!stall) begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
`ifdef FPU_MULT_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  // Datapath registers are qualified by the valid bits, so they carry no reset
  always_ff @(posedge CLK) begin
    if (!stall) begin
      sign_p1_q    <= sign_p1_d;
      spc_p1_q     <= spc_p1_d;
      spc_val_p1_q <= spc_val_p1_d;
      exp_p1_q     <= exp_p1_d;
      mant_a_p1_q  <= mant_a_p1_d;
      mant_b_p1_q  <= mant_b_p1_d;
      sign_p2_q    <= sign_p2_d;
      spc_p2_q     <= spc_p2_d;
      spc_val_p2_q <= spc_val_p2_d;
      exp_p2_q     <= exp_p2_d;
      prod_p2_q    <= prod_p2_d;
`ifdef FPU_MULT_FLAGS_EN
      inv_p1_q     <= inv_p1_d;
      inv_p2_q     <= inv_p2_d;
`endif
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Directed-vector bench for float_mult_pipe at half precision (EXP_W=5, FRAC_W=10).
module tb_float_mult_pipe;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [15:0] float1 = '0;
  logic [15:0] float2 = '0;
  logic [15:0] product;
`ifdef FPU_MULT_FLAGS_EN
  logic [3:0] flags;
  logic [3:0] gotf_q[$];
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [15:0] got_q[$];
  int got_cyc[$];
  int acc_cyc[$];
  logic [15:0] va[8], vb[8], ve[8];
  logic [3:0]  vf[8];

  float_mult_pipe #(.EXP_W(5), .FRAC_W(10)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .float1(float1), .float2(float2), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FPU_MULT_FLAGS_EN
    .flags(flags),
`endif
    .product(product)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (nRST) begin
      if (out_valid && out_ready) begin
        got_q.push_back(product);
        got_cyc.push_back(cyc);
`ifdef FPU_MULT_FLAGS_EN
        gotf_q.push_back(flags);
`endif
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
`ifdef FPU_MULT_FLAGS_EN
    gotf_q.delete();
`endif
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    float1 = a;
    float2 = b;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (in_ready) begin
        step();
        return;
      end
      step();
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout %h x %h: in_ready 0, required 1", a, b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_results(input int n, output bit to);
    to = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (got_q.size() >= n) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic issue_all(input int n, output bit to);
    clear_logs();
    for (int i = 0; i < n; i++) do_op(va[i], vb[i]);
    idle(1);
    wait_results(n, to);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
    n_vec++;
    if (product !== 16'h0000) begin n_err++; $display("FAIL reset_product: %h, required 0000", product); end
    #2 nRST = 1'b1;
    step();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    bit to;
    va[0] = 16'h3C00; vb[0] = 16'h4000; ve[0] = 16'h4000;
    va[1] = 16'h3E00; vb[1] = 16'h3E00; ve[1] = 16'h4080;
    issue_all(2, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL b2b_timeout: %0d results, required 2", got_q.size()); end
    n_vec++;
    if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 1)
      begin n_err++; $display("FAIL b2b_accept: %0d accepts, required 2 on consecutive cycles", acc_cyc.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== ve[i]) begin n_err++; $display("FAIL b2b[%0d]: product %h, required %h", i, got_q[i], ve[i]); end
      n_vec++;
      if (got_cyc[i] - acc_cyc[i] != 3)
        begin n_err++; $display("FAIL b2b_latency[%0d]: %0d cycles, required 3", i, got_cyc[i] - acc_cyc[i]); end
`ifdef FPU_MULT_FLAGS_EN
      n_vec++;
      if (gotf_q[i] !== 4'b0000) begin n_err++; $display("FAIL b2b_flags[%0d]: %b, required 0000", i, gotf_q[i]); end
`endif
    end
    n_vec++;
    if (got_cyc[1] - got_cyc[0] != 1)
      begin n_err++; $display("FAIL b2b_spacing: %0d cycles, required 1", got_cyc[1] - got_cyc[0]); end
  endtask

  task automatic test_rounding();
    bit to;
    va[0] = 16'h3C01; vb[0] = 16'h3C01; ve[0] = 16'h3C02; vf[0] = 4'b0001;
    va[1] = 16'h3E00; vb[1] = 16'h3C01; ve[1] = 16'h3E02; vf[1] = 4'b0001;
    issue_all(2, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL rounding_timeout: %0d results, required 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== ve[i])
        begin n_err++; $display("FAIL rounding[%0d] %h x %h: product %h, required %h (flags %b)", i, va[i], vb[i], got_q[i], ve[i], vf[i]); end
`ifdef FPU_MULT_FLAGS_EN
      n_vec++;
      if (gotf_q[i] !== vf[i]) begin n_err++; $display("FAIL rounding_flags[%0d]: %b, required %b", i, gotf_q[i], vf[i]); end
`endif
    end
  endtask

  task automatic test_specials();
    bit to;
    va[0] = 16'h7BFF; vb[0] = 16'h7BFF; ve[0] = 16'h7C00; vf[0] = 4'b0101;
    va[1] = 16'hFC00; vb[1] = 16'h4000; ve[1] = 16'hFC00; vf[1] = 4'b0000;
    va[2] = 16'h7C00; vb[2] = 16'h0000; ve[2] = 16'h7E00; vf[2] = 4'b1000;
    va[3] = 16'h7C01; vb[3] = 16'h3C00; ve[3] = 16'h7E00; vf[3] = 4'b1000;
    issue_all(4, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL specials_timeout: %0d results, required 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got_q[i] !== ve[i])
        begin n_err++; $display("FAIL specials[%0d] %h x %h: product %h, required %h (flags %b)", i, va[i], vb[i], got_q[i], ve[i], vf[i]); end
`ifdef FPU_MULT_FLAGS_EN
      n_vec++;
      if (gotf_q[i] !== vf[i]) begin n_err++; $display("FAIL specials_flags[%0d]: %b, required %b", i, gotf_q[i], vf[i]); end
`endif
    end
  endtask

  task automatic test_flush();
    bit to;
    va[0] = 16'h0400; vb[0] = 16'h3800; ve[0] = 16'h0000; vf[0] = 4'b0011;
    va[1] = 16'h8001; vb[1] = 16'h4000; ve[1] = 16'h8000; vf[1] = 4'b0000;
    issue_all(2, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL flush_timeout: %0d results, required 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== ve[i])
        begin n_err++; $display("FAIL flush[%0d] %h x %h: product %h, required %h (flags %b)", i, va[i], vb[i], got_q[i], ve[i], vf[i]); end
`ifdef FPU_MULT_FLAGS_EN
      n_vec++;
      if (gotf_q[i] !== vf[i]) begin n_err++; $display("FAIL flush_flags[%0d]: %b, required %b", i, gotf_q[i], vf[i]); end
`endif
    end
  endtask

  task automatic test_backpressure();
    bit to;
    va[0] = 16'h3C00; vb[0] = 16'h4000; ve[0] = 16'h4000;
    va[1] = 16'h3E00; vb[1] = 16'h3E00; ve[1] = 16'h4080;
    va[2] = 16'h3C01; vb[2] = 16'h3C01; ve[2] = 16'h3C02;
    va[3] = 16'h3E00; vb[3] = 16'h3C01; ve[3] = 16'h3E02;
    va[4] = 16'h4000; vb[4] = 16'h4000; ve[4] = 16'h4400;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_op(va[i], vb[i]);
    in_valid = 1'b1;
    float1 = va[3];
    float2 = vb[3];
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: %b, required 1", k, out_valid); end
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: %b, required 0", k, in_ready); end
      n_vec++;
      if (product !== ve[0]) begin n_err++; $display("FAIL stall_product[%0d]: %h, required %h", k, product, ve[0]); end
      step();
    end
    out_ready = 1'b1;
    do_op(va[3], vb[3]);
    do_op(va[4], vb[4]);
    idle(1);
    wait_results(5, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL bp_timeout: %0d results, required 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (got_q[i] !== ve[i]) begin n_err++; $display("FAIL bp_order[%0d]: product %h, required %h", i, got_q[i], ve[i]); end
    end
    repeat (6) step();
    n_vec++;
    if (got_q.size() != 5) begin n_err++; $display("FAIL bp_count: %0d results, required 5", got_q.size()); end
    n_vec++;
    if (acc_cyc.size() != 5) begin n_err++; $display("FAIL bp_accepts: %0d accepts, required 5", acc_cyc.size()); end
  endtask

  task automatic test_reset_midstream();
    bit to;
    clear_logs();
    out_ready = 1'b0;
    do_op(16'h3C00, 16'h4000);
    do_op(16'h3E00, 16'h3E00);
    do_op(16'h4000, 16'h4000);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: %b, required 1", out_valid); end
    #1 nRST = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_async_valid: %b, required 0", out_valid); end
    n_vec++;
    if (product !== 16'h0000) begin n_err++; $display("FAIL midrst_product: %h, required 0000", product); end
    step();
    step();
    nRST = 1'b1;
    out_ready = 1'b1;
    repeat (8) step();
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL midrst_stale: %0d results, required 0", got_q.size()); end
    do_op(16'h3C00, 16'h3E00);
    idle(1);
    wait_results(1, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL midrst_timeout: %0d results, required 1", got_q.size()); end
    n_vec++;
    if (got_q[0] !== 16'h3E00) begin n_err++; $display("FAIL midrst_after: product %h, required 3E00", got_q[0]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_rounding();
    test_specials();
    test_flush();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float_mult_pipe.md
Name: float_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 style floating-point multiplier with valid/ready handshakes on input and output.
- Successor to the half-precision combinational multiplier:
  - generalised exponent/fraction widths
  - round-to-nearest-even instead of truncation
  - correct exponent overflow/underflow handling
  - IEEE special-value semantics
- Sits between the FPU operand dispatch and the FPU result writeback arbiter.

Parameters:
- EXP_W, 5, exponent field width (5 = half, 8 = single).
- FRAC_W, 10, stored fraction width (10 = half, 23 = single).
- FLOAT_W is derived as 1+EXP_W+FRAC_W; it is not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- float1  in  FLOAT_W  operand A.
- float2  in  FLOAT_W  operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  FLOAT_W  rounded result.

Behaviour:
- One clock domain, CLK. Reset nRST is asynchronous, active-low.
- Reset values:
  - All stage valid bits 0.
  - out_valid = 0, product = 0.
  - in_ready = 1 the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight results. No partial output appears.
- Pipeline timing:
  - Latency is exactly 3 cycles from the accept edge (in_valid & in_ready) to out_valid, when there is no stall.
  - Throughput is 1 per cycle.
- Stages:
  - S1: unpack, classify, sign = s1^s2, exponent sum e1+e2-bias in signed EXP_W+2 bits.
  - S2: (FRAC_W+1)x(FRAC_W+1) mantissa multiply.
  - S3: normalise, RNE round, pack.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - On stall, every stage register holds, including bubbles. There is no bubble collapse.
  - product and out_valid must stay stable while stalled.
- Subnormals are flushed to zero:
  - Any input with exp==0 is treated as a signed zero.
  - Any result whose biased exponent after rounding is < 1 becomes a signed zero.
- Special cases (priority order):
  - Either operand NaN, or zero x inf → canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0.
  - Else either operand inf → inf with XOR sign.
  - Else either operand zero → zero with XOR sign.
- Normal path:
  - Take the 2*FRAC_W+2-bit product.
  - If the top bit is set, shift right 1 and increment the exponent.
  - Guard = bit below the LSB. Sticky = OR of the remaining lower bits.
  - Round up iff guard & (sticky | lsb).
  - If rounding carries out, the mantissa becomes 1.0 and the exponent increments.
  - Biased exponent ≥ all-ones → signed inf.

Optional Feature:
- Macro: FPU_MULT_FLAGS_EN.
- When defined:
  - Add output port flags, 4 bits, {invalid, overflow, underflow, inexact}, registered alongside product.
  - Flags are valid when out_valid is high, 0 on reset, and held while stalled.
  - invalid: sNaN input (exp all ones, frac MSB 0, frac nonzero) or zero x inf.
  - overflow: rounded result exceeds max finite.
  - underflow: nonzero exact result flushed to zero.
  - inexact: guard|sticky, or overflow, or underflow.
- When not defined: the port is absent and no flag logic is generated.

Test Plan (defaults EXP_W=5, FRAC_W=10):
- Basic products, back-to-back: 0x3C00 x 0x4000, then 0x3E00 x 0x3E00 on consecutive cycles → 0x4000 and 0x4080 on consecutive cycles, each exactly 3 cycles after its accept.
- Rounding:
  - 0x3C01 x 0x3C01 → 0x3C02 (inexact, rounds down).
  - 0x3E00 x 0x3C01 → 0x3E02 (tie, rounds to even).
- Overflow and specials:
  - 0x7BFF x 0x7BFF → 0x7C00 (flags 0101).
  - 0xFC00 x 0x4000 → 0xFC00.
  - 0x7C00 x 0x0000 → 0x7E00 (flags 1000).
  - 0x7C01 x 0x3C00 → 0x7E00 (invalid).
- Underflow / flush-to-zero:
  - 0x0400 x 0x3800 → 0x0000 (flags 0011).
  - 0x8001 x 0x4000 → 0x8000 (subnormal input flushed, sign kept).
- Backpressure and reset:
  - Stream 5 operations, hold out_ready=0 for 4 cycles → in_ready=0 while out_valid is high, product stable, no loss or duplication, order preserved.
  - Assert nRST mid-stream → out_valid drops asynchronously, and no stale result appears after release.
